// File: rtl/lane_edge_tracker.sv
// lane_edge_tracker
//
// Splits each frame into NUM_BANDS horizontal bands. For each band it tracks
// the innermost Sobel edge on the left half of the image (largest x) and on
// the right half (smallest x). A side counts as found only when it collects
// at least MIN_HITS edge hits in the frame. Each band keeps its last good
// position (held x) across frames. After the frame ends, one result beat per
// band is streamed out over a valid/ready handshake, band 0 first.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   vs_in                frame-active level (rise = frame start, fall = end)
//   de_in, edge_detected pixel valid and Sobel edge flag
//   x_coord, y_coord     pixel position
//   result_ready         consumer accepts the current beat
//   processing           high while accumulating a frame
//   result_*             per-band result beat (held x, center, found flags)
//   frame_done           one-cycle pulse after the last beat transfers
//   skipped_frames       saturating count of frames that began during REPORT
module lane_edge_tracker #(
    parameter int  IMG_WIDTH  = 1280,
    parameter int  IMG_HEIGHT = 720,
    parameter int  NUM_BANDS  = 4,
    parameter int  MIN_HITS   = 8,
    parameter int  X_W        = 11,
    parameter int  Y_W        = 10,
    localparam int BAND_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic              edge_detected,
    input  logic [X_W-1:0]    x_coord,
    input  logic [Y_W-1:0]    y_coord,
    input  logic              result_ready,
    output logic              processing,
    output logic              result_valid,
    output logic [BAND_W-1:0] result_band,
    output logic [X_W-1:0]    result_left_x,
    output logic [X_W-1:0]    result_right_x,
    output logic [X_W-1:0]    result_center_x,
    output logic              result_found_left,
    output logic              result_found_right,
    output logic              frame_done,
    output logic [7:0]        skipped_frames
);
    localparam int HIT_W  = $clog2(MIN_HITS + 1);
    localparam int BAND_H = IMG_HEIGHT / NUM_BANDS;

    localparam logic [X_W:0]        X_LIMIT   = (X_W + 1)'(IMG_WIDTH);
    localparam logic [X_W:0]        X_HALF    = (X_W + 1)'(IMG_WIDTH / 2);
    localparam logic [Y_W:0]        Y_LIMIT   = (Y_W + 1)'(IMG_HEIGHT);
    localparam logic [X_W-1:0]      LEFT_RST  = X_W'(IMG_WIDTH / 4);
    localparam logic [X_W-1:0]      RIGHT_RST = X_W'(3 * IMG_WIDTH / 4);
    localparam logic [HIT_W-1:0]    HIT_MAX   = HIT_W'(MIN_HITS);
    localparam logic [BAND_W-1:0]   LAST_BAND = BAND_W'(NUM_BANDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    genvar gi;

    // Control state
    logic [1:0]        state_q, state_d;
    logic              vs_prev_q, vs_prev_d;
    logic              upd_q, upd_d;          // held-x update cycle at REPORT entry
    logic              valid_q, valid_d;
    logic [BAND_W-1:0] band_q, band_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        skipped_q, skipped_d;

    // Registered qualifying sample (first pipeline stage)
    logic              s1_valid_q, s1_valid_d;
    logic [BAND_W-1:0] s1_band_q, s1_band_d;
    logic              s1_right_q, s1_right_d;
    logic [X_W-1:0]    s1_x_q, s1_x_d;

    // Per-band state
    logic [HIT_W-1:0]     hits_l_q [NUM_BANDS];
    logic [HIT_W-1:0]     hits_l_d [NUM_BANDS];
    logic [HIT_W-1:0]     hits_r_q [NUM_BANDS];
    logic [HIT_W-1:0]     hits_r_d [NUM_BANDS];
    logic [X_W-1:0]       inner_l_q[NUM_BANDS];
    logic [X_W-1:0]       inner_l_d[NUM_BANDS];
    logic [X_W-1:0]       inner_r_q[NUM_BANDS];
    logic [X_W-1:0]       inner_r_d[NUM_BANDS];
    logic [X_W-1:0]       held_l_q [NUM_BANDS];
    logic [X_W-1:0]       held_l_d [NUM_BANDS];
    logic [X_W-1:0]       held_r_q [NUM_BANDS];
    logic [X_W-1:0]       held_r_d [NUM_BANDS];
    logic [NUM_BANDS-1:0] found_l_q, found_l_d;
    logic [NUM_BANDS-1:0] found_r_q, found_r_d;

    logic              vs_rise, vs_fall, xfer, last_xfer, clear_frame;
    logic              x_in_range, y_in_range;
    logic [BAND_W-1:0] sample_band;
    logic [NUM_BANDS-1:0] y_ge;
    logic [X_W:0]      center_sum;

    // Band lookup without a divider: y_ge[gi] is set when the row is at or
    // past the first row of band gi; the highest set bit is the band. Rows
    // beyond NUM_BANDS*BAND_H fall into the last band naturally.
    generate
        for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band_cmp
            localparam logic [Y_W:0] BAND_START = (Y_W + 1)'(gi * BAND_H);
            assign y_ge[gi] = ({1'b0, y_coord} >= BAND_START);
        end
    endgenerate

    always_comb begin
        sample_band = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (y_ge[b]) sample_band = BAND_W'(b);
        end
    end

    assign x_in_range = ({1'b0, x_coord} < X_LIMIT);
    assign y_in_range = ({1'b0, y_coord} < Y_LIMIT);

    assign vs_rise   = vs_in & ~vs_prev_q;
    assign vs_fall   = ~vs_in & vs_prev_q;
    assign xfer      = valid_q & result_ready;
    assign last_xfer = xfer && (band_q == LAST_BAND);

    // Sample stage
    always_comb begin
        vs_prev_d  = vs_in;
        s1_valid_d = (state_q == S_ACCUM) && vs_in && de_in && edge_detected
                     && x_in_range && y_in_range;
        s1_band_d  = sample_band;
        s1_right_d = ({1'b0, x_coord} >= X_HALF);
        s1_x_d     = x_coord;
    end

    // Frame / report sequencing
    always_comb begin
        state_d      = state_q;
        upd_d        = 1'b0;
        valid_d      = valid_q;
        band_d       = band_q;
        frame_done_d = 1'b0;
        skipped_d    = skipped_q;
        clear_frame  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vs_rise) begin
                    state_d     = S_ACCUM;
                    clear_frame = 1'b1;
                end
            end
            S_ACCUM: begin
                if (vs_fall) begin
                    state_d = S_REPORT;
                    upd_d   = 1'b1;
                end
            end
            S_REPORT: begin
                if (upd_q) valid_d = 1'b1;
                if (last_xfer) begin
                    valid_d      = 1'b0;
                    band_d       = '0;
                    frame_done_d = 1'b1;
                    // A frame starting exactly on the final transfer is not lost.
                    if (vs_rise) begin
                        state_d     = S_ACCUM;
                        clear_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (xfer) band_d = band_q + BAND_W'(1);
                    if (vs_rise && skipped_q != 8'hFF) skipped_d = skipped_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-band accumulation, clear and held-x update
    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            hits_l_d[b]  = hits_l_q[b];
            hits_r_d[b]  = hits_r_q[b];
            inner_l_d[b] = inner_l_q[b];
            inner_r_d[b] = inner_r_q[b];
            held_l_d[b]  = held_l_q[b];
            held_r_d[b]  = held_r_q[b];
        end
        found_l_d = found_l_q;
        found_r_d = found_r_q;

        for (int b = 0; b < NUM_BANDS; b++) begin
            if (clear_frame) begin
                hits_l_d[b]  = '0;
                hits_r_d[b]  = '0;
                inner_l_d[b] = '0;
                inner_r_d[b] = '1;  // any real right-side x is smaller
            end else if (s1_valid_q && s1_band_q == BAND_W'(b)) begin
                if (s1_right_q) begin
                    if (hits_r_q[b] != HIT_MAX) hits_r_d[b] = hits_r_q[b] + HIT_W'(1);
                    if (s1_x_q < inner_r_q[b]) inner_r_d[b] = s1_x_q;
                end else begin
                    if (hits_l_q[b] != HIT_MAX) hits_l_d[b] = hits_l_q[b] + HIT_W'(1);
                    if (s1_x_q > inner_l_q[b]) inner_l_d[b] = s1_x_q;
                end
            end

            if (upd_q) begin
                found_l_d[b] = (hits_l_q[b] >= HIT_MAX);
                found_r_d[b] = (hits_r_q[b] >= HIT_MAX);
                if (hits_l_q[b] >= HIT_MAX) held_l_d[b] = inner_l_q[b];
                if (hits_r_q[b] >= HIT_MAX) held_r_d[b] = inner_r_q[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vs_prev_q    <= 1'b0;
            upd_q        <= 1'b0;
            valid_q      <= 1'b0;
            band_q       <= '0;
            frame_done_q <= 1'b0;
            skipped_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_band_q    <= '0;
            s1_right_q   <= 1'b0;
            s1_x_q       <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                hits_l_q[b]  <= '0;
                hits_r_q[b]  <= '0;
                inner_l_q[b] <= '0;
                inner_r_q[b] <= '1;
                held_l_q[b]  <= LEFT_RST;
                held_r_q[b]  <= RIGHT_RST;
            end
            found_l_q <= '0;
            found_r_q <= '0;
        end else begin
            state_q      <= state_d;
            vs_prev_q    <= vs_prev_d;
            upd_q        <= upd_d;
            valid_q      <= valid_d;
            band_q       <= band_d;
            frame_done_q <= frame_done_d;
            skipped_q    <= skipped_d;
            s1_valid_q   <= s1_valid_d;
            s1_band_q    <= s1_band_d;
            s1_right_q   <= s1_right_d;
            s1_x_q       <= s1_x_d;
            for (int b = 0; b < NUM_BANDS; b++) begin
                hits_l_q[b]  <= hits_l_d[b];
                hits_r_q[b]  <= hits_r_d[b];
                inner_l_q[b] <= inner_l_d[b];
                inner_r_q[b] <= inner_r_d[b];
                held_l_q[b]  <= held_l_d[b];
                held_r_q[b]  <= held_r_d[b];
            end
            found_l_q <= found_l_d;
            found_r_q <= found_r_d;
        end
    end

    // Beat outputs read held state directly, so they cannot change while a
    // beat is stalled: held state only moves in the update cycle before valid.
    assign center_sum = {1'b0, held_l_q[band_q]} + {1'b0, held_r_q[band_q]};

    assign processing         = (state_q == S_ACCUM);
    assign result_valid       = valid_q;
    assign result_band        = band_q;
    assign result_left_x      = held_l_q[band_q];
    assign result_right_x     = held_r_q[band_q];
    assign result_center_x    = center_sum[X_W:1];
    assign result_found_left  = found_l_q[band_q];
    assign result_found_right = found_r_q[band_q];
    assign frame_done         = frame_done_q;
    assign skipped_frames     = skipped_q;

endmodule

// File: tb/tb_lane_edge_tracker.sv
// Self-checking bench for lane_edge_tracker with default parameters
// (1280x720, 4 bands, MIN_HITS=8). Frames are described by a stimulus table
// and an expected-result table; multi-cycle corner cases are hand sequenced.
module tb_lane_edge_tracker;
    localparam int NB = 4;
    localparam int NS = 18;
    localparam int NE = 36;

    typedef struct {
        int frame;
        int x;
        int y;
        int n;
    } stim_t;

    typedef struct {
        int frame;
        int band;
        int lx;
        int rx;
        int cx;
        int fl;
        int fr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_in, de_in, edge_detected;
    logic [10:0] x_coord;
    logic [9:0]  y_coord;
    logic        result_ready;
    logic        processing, result_valid;
    logic [1:0]  result_band;
    logic [10:0] result_left_x, result_right_x, result_center_x;
    logic        result_found_left, result_found_right, frame_done;
    logic [7:0]  skipped_frames;

    int checks = 0;
    int errors = 0;
    stim_t stims[NS];
    exp_t  exps[NE];
    int    ne_fill = 0;

    lane_edge_tracker dut (
        .clk                (clk),
        .reset              (reset),
        .vs_in              (vs_in),
        .de_in              (de_in),
        .edge_detected      (edge_detected),
        .x_coord            (x_coord),
        .y_coord            (y_coord),
        .result_ready       (result_ready),
        .processing         (processing),
        .result_valid       (result_valid),
        .result_band        (result_band),
        .result_left_x      (result_left_x),
        .result_right_x     (result_right_x),
        .result_center_x    (result_center_x),
        .result_found_left  (result_found_left),
        .result_found_right (result_found_right),
        .frame_done         (frame_done),
        .skipped_frames     (skipped_frames)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic add_exp(input int f, input int b, input int lx, input int rx,
                           input int cx, input int fl, input int fr);
        exps[ne_fill] = '{f, b, lx, rx, cx, fl, fr};
        ne_fill++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_processing"}, int'(processing), 0);
        check({tag, "_valid"}, int'(result_valid), 0);
        check({tag, "_band"}, int'(result_band), 0);
        check({tag, "_left"}, int'(result_left_x), 320);
        check({tag, "_right"}, int'(result_right_x), 960);
        check({tag, "_center"}, int'(result_center_x), 640);
        check({tag, "_found_l"}, int'(result_found_left), 0);
        check({tag, "_found_r"}, int'(result_found_right), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_skipped"}, int'(skipped_frames), 0);
    endtask

    // Drives every stimulus row of frame f; vs_in must already be high.
    task automatic send_stims(input int f);
        for (int i = 0; i < NS; i++) begin
            if (stims[i].frame == f) begin
                x_coord       = 11'(stims[i].x);
                y_coord       = 10'(stims[i].y);
                de_in         = 1'b1;
                edge_detected = 1'b1;
                for (int k = 0; k < stims[i].n; k++) tick();
            end
        end
        de_in         = 1'b0;
        edge_detected = 1'b0;
    endtask

    // Receives all beats of frame f, checking order, every field of each
    // presented beat (also on stalled cycles), and a single frame_done pulse.
    task automatic collect(input int f, input int stall_band, input int stall_cyc);
        int   nb;
        int   fd;
        int   stalls;
        int   guard;
        exp_t e;
        nb     = 0;
        fd     = 0;
        stalls = stall_cyc;
        guard  = 0;
        while (nb < NB && guard < 40) begin
            if (result_valid) begin
                e = '{-1, -1, 0, 0, 0, 0, 0};
                for (int i = 0; i < NE; i++)
                    if (exps[i].frame == f && exps[i].band == nb) e = exps[i];
                check($sformatf("f%0d_b%0d_order", f, nb), int'(result_band), nb);
                check($sformatf("f%0d_b%0d_left", f, nb), int'(result_left_x), e.lx);
                check($sformatf("f%0d_b%0d_right", f, nb), int'(result_right_x), e.rx);
                check($sformatf("f%0d_b%0d_center", f, nb), int'(result_center_x), e.cx);
                check($sformatf("f%0d_b%0d_found_l", f, nb), int'(result_found_left), e.fl);
                check($sformatf("f%0d_b%0d_found_r", f, nb), int'(result_found_right), e.fr);
                if (nb == stall_band && stalls > 0) begin
                    result_ready = 1'b0;
                    stalls--;
                end else begin
                    result_ready = 1'b1;
                    nb++;
                end
            end else begin
                result_ready = 1'b1;
            end
            tick();
            guard++;
            if (frame_done) fd++;
        end
        check($sformatf("f%0d_beats", f), nb, NB);
        check($sformatf("f%0d_valid_after", f), int'(result_valid), 0);
        tick();
        if (frame_done) fd++;
        check($sformatf("f%0d_frame_done_pulses", f), fd, 1);
    endtask

    task automatic run_frame(input int f, input int stall_band);
        vs_in = 1'b1;
        tick();
        check($sformatf("f%0d_processing_rise", f), int'(processing), 1);
        send_stims(f);
        vs_in = 1'b0;
        tick();
        check($sformatf("f%0d_processing_fall", f), int'(processing), 0);
        check($sformatf("f%0d_valid_lat1", f), int'(result_valid), 0);
        tick();
        check($sformatf("f%0d_valid_lat2", f), int'(result_valid), 1);
        collect(f, stall_band, 5);
    endtask

    initial begin
        // Stimulus table: frame, x, y, count
        stims[0]  = '{0, 300, 50, 8};
        stims[1]  = '{0, 1000, 50, 10};
        stims[2]  = '{1, 100, 400, 8};
        stims[3]  = '{1, 900, 400, 8};
        stims[4]  = '{1, 500, 400, 8};
        stims[5]  = '{1, 700, 400, 8};
        stims[6]  = '{1, 200, 400, 8};
        stims[7]  = '{1, 1100, 400, 8};
        stims[8]  = '{2, 400, 200, 8};
        stims[9]  = '{3, 600, 200, 7};
        stims[10] = '{3, 1280, 100, 8};
        stims[11] = '{3, 100, 720, 8};
        stims[12] = '{4, 639, 719, 8};
        stims[13] = '{4, 640, 540, 8};
        stims[14] = '{4, 100, 539, 8};
        stims[15] = '{5, 450, 200, 8};
        stims[16] = '{6, 200, 50, 8};
        stims[17] = '{7, 700, 50, 8};

        // Expected beats: frame, band, left, right, center, found_l, found_r
        add_exp(0, 0, 300, 1000, 650, 1, 1);
        add_exp(0, 1, 320, 960, 640, 0, 0);
        add_exp(0, 2, 320, 960, 640, 0, 0);
        add_exp(0, 3, 320, 960, 640, 0, 0);
        add_exp(1, 0, 300, 1000, 650, 0, 0);
        add_exp(1, 1, 320, 960, 640, 0, 0);
        add_exp(1, 2, 500, 700, 600, 1, 1);
        add_exp(1, 3, 320, 960, 640, 0, 0);
        add_exp(2, 0, 300, 1000, 650, 0, 0);
        add_exp(2, 1, 400, 960, 680, 1, 0);
        add_exp(2, 2, 500, 700, 600, 0, 0);
        add_exp(2, 3, 320, 960, 640, 0, 0);
        add_exp(3, 0, 300, 1000, 650, 0, 0);
        add_exp(3, 1, 400, 960, 680, 0, 0);
        add_exp(3, 2, 500, 700, 600, 0, 0);
        add_exp(3, 3, 320, 960, 640, 0, 0);
        add_exp(4, 0, 300, 1000, 650, 0, 0);
        add_exp(4, 1, 400, 960, 680, 0, 0);
        add_exp(4, 2, 100, 700, 400, 1, 0);
        add_exp(4, 3, 639, 640, 639, 1, 1);
        add_exp(5, 0, 300, 1000, 650, 0, 0);
        add_exp(5, 1, 450, 960, 705, 1, 0);
        add_exp(5, 2, 100, 700, 400, 0, 0);
        add_exp(5, 3, 639, 640, 639, 0, 0);
        add_exp(6, 0, 200, 1000, 600, 1, 0);
        add_exp(6, 1, 450, 960, 705, 0, 0);
        add_exp(6, 2, 100, 700, 400, 0, 0);
        add_exp(6, 3, 639, 640, 639, 0, 0);
        add_exp(7, 0, 200, 700, 450, 0, 1);
        add_exp(7, 1, 450, 960, 705, 0, 0);
        add_exp(7, 2, 100, 700, 400, 0, 0);
        add_exp(7, 3, 639, 640, 639, 0, 0);
        add_exp(8, 0, 320, 960, 640, 0, 0);
        add_exp(8, 1, 320, 960, 640, 0, 0);
        add_exp(8, 2, 320, 960, 640, 0, 0);
        add_exp(8, 3, 320, 960, 640, 0, 0);

        reset         = 1'b1;
        vs_in         = 1'b0;
        de_in         = 1'b0;
        edge_detected = 1'b0;
        x_coord       = '0;
        y_coord       = '0;
        result_ready  = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Frames 0..5: single hit, innermost, persistence, range/boundaries,
        // and backpressure on band 1 in frame 5.
        for (int f = 0; f <= 5; f++) run_frame(f, (f == 5) ? 1 : -1);

        // Frame 6: vs rises while a beat is stalled in REPORT -> skipped.
        result_ready = 1'b0;
        vs_in = 1'b1;
        tick();
        send_stims(6);
        vs_in = 1'b0;
        tick();
        tick();
        check("skip_valid_before", int'(result_valid), 1);
        vs_in = 1'b1;
        tick();
        check("skip_count", int'(skipped_frames), 1);
        check("skip_processing", int'(processing), 0);
        tick();
        check("skip_count_hold", int'(skipped_frames), 1);
        check("skip_processing_hold", int'(processing), 0);
        collect(6, -1, 0);
        check("skip_idle_processing", int'(processing), 0);
        vs_in = 1'b0;
        tick();
        tick();
        check("idle_fall_processing", int'(processing), 0);
        check("idle_fall_valid", int'(result_valid), 0);

        // Frame 7: vs rises on the final-transfer cycle -> straight to ACCUM.
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        tick();
        tick();
        result_ready = 1'b1;
        tick();
        tick();
        tick();
        check("final_band3_present", int'(result_band), 3);
        check("final_valid_present", int'(result_valid), 1);
        vs_in = 1'b1;
        tick();
        check("final_rise_processing", int'(processing), 1);
        check("final_rise_frame_done", int'(frame_done), 1);
        check("final_rise_valid", int'(result_valid), 0);
        check("final_rise_skipped", int'(skipped_frames), 1);
        send_stims(7);
        vs_in = 1'b0;
        tick();
        tick();
        collect(7, -1, 0);

        // Reset mid-ACCUM.
        vs_in = 1'b1;
        tick();
        x_coord       = 11'd300;
        y_coord       = 10'd50;
        de_in         = 1'b1;
        edge_detected = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        check("mid_accum_processing", int'(processing), 1);
        reset         = 1'b1;
        vs_in         = 1'b0;
        de_in         = 1'b0;
        edge_detected = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        tick();
        run_frame(8, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_edge_tracker.md
# lane_edge_tracker

Parametrised successor to the single-edge vertical tracker in the lane pipeline. Splits each frame into `NUM_BANDS` horizontal bands and, per band, tracks the innermost Sobel edge on the left and right halves of the image, with hit-count qualification and per-band persistence of the last good position. Sits between the Sobel stage and the steering/overlay logic. Results are streamed out band-by-band over a valid/ready interface after each frame.

## Interface
- `IMG_WIDTH`, default 1280: active pixels per line.
- `IMG_HEIGHT`, default 720: active lines per frame.
- `NUM_BANDS`, default 4: horizontal bands per frame. Must be ≥1 and ≤ `IMG_HEIGHT`.
- `MIN_HITS`, default 8: edge hits a side needs in one frame to count as found. Must be ≥1.
- `X_W`, default 11: width of x coordinates.
- `Y_W`, default 10: width of y coordinates.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `vs_in` in 1: frame-active level; a rising edge starts a frame and a falling edge ends it.
- `de_in` in 1: pixel valid.
- `edge_detected` in 1: Sobel edge flag for the current pixel.
- `x_coord` in `X_W`: pixel column.
- `y_coord` in `Y_W`: pixel row.
- `result_ready` in 1: consumer accepts the result beat.
- `processing` out 1: high while the block is in ACCUM.
- `result_valid` out 1: a result beat is presented.
- `result_band` out `$clog2(NUM_BANDS)` (minimum 1): band index of the beat.
- `result_left_x` out `X_W`: left boundary x.
- `result_right_x` out `X_W`: right boundary x.
- `result_center_x` out `X_W`: (left + right) >> 1, computed at `X_W`+1 bits.
- `result_found_left` out 1: left side qualified this frame.
- `result_found_right` out 1: right side qualified this frame.
- `frame_done` out 1: one-cycle pulse after the last beat.
- `skipped_frames` out 8: saturating count of frames ignored.

## Operation
- States: IDLE, ACCUM, REPORT. Reset enters IDLE.
- Band mapping:
  - `BAND_H = IMG_HEIGHT / NUM_BANDS`.
  - band = `y_coord / BAND_H`, implemented as comparator chain, no divider.
  - Rows past `NUM_BANDS*BAND_H` belong to the last band.
- Side mapping: left if `x_coord < IMG_WIDTH/2`, otherwise right.
- Ignored samples: `x_coord ≥ IMG_WIDTH` or `y_coord ≥ IMG_HEIGHT`.
- Qualifying sample: state is ACCUM, `vs_in`=1, `de_in`=1, `edge_detected`=1, and coordinates are in range.
- Per band and side, registered state:
  - hit counter, saturating at `MIN_HITS`.
  - innermost x: left keeps the maximum x, right keeps the minimum x.
  - held x: the persistent value.
- Hit counter and innermost x are cleared at the start of every frame.
- Transitions:
  - IDLE→ACCUM on a `vs_in` rising edge (`vs_in`=1 and `vs_prev`=0).
  - ACCUM→REPORT on a `vs_in` falling edge.
  - REPORT→IDLE after the handshake of band `NUM_BANDS-1`.
- Held-x update on entry to REPORT: for each side with hits ≥ `MIN_HITS`, held x ← innermost x and found=1. Otherwise held x is unchanged and found=0.
- REPORT output order: band 0 first, up to `NUM_BANDS-1`. Each beat presents held x values and found flags.
- Handshake:
  - A beat transfers on `result_valid`&`result_ready`.
  - Beat outputs are stable while `result_valid`=1 and `result_ready`=0.
- `frame_done` pulses on the cycle after the final transfer.
- vs rising edge while in REPORT:
  - The frame is skipped; the block does not accumulate it.
  - `skipped_frames` increments, saturating at 255.
  - Exception: a rising edge on the same cycle as the final transfer is accepted and the next state is ACCUM directly.
- A vs falling edge in IDLE is ignored.

## Timing
- Reset values:
  - `processing`=0, `result_valid`=0, `result_band`=0, `result_found_left`/`result_found_right`=0, `frame_done`=0, `skipped_frames`=0.
  - `result_left_x`=`IMG_WIDTH/4`, `result_right_x`=`3*IMG_WIDTH/4`, `result_center_x`=`IMG_WIDTH/2`.
  - Held x values reset to `IMG_WIDTH/4` (left) and `3*IMG_WIDTH/4` (right); counters cleared.
- Reset mid-frame or mid-REPORT: all state returns to the reset values on the next edge, and any pending beats are discarded.
- Qualifying samples are registered, then committed to band state one cycle later. A sample on the last cycle with `vs_in`=1 is still counted.
- `processing` rises one cycle after the vs rising edge and falls one cycle after the vs falling edge.
- `result_valid` rises 2 cycles after the vs falling edge. One cycle is the commit stage; one is the held-x update.
- With `result_ready` held at 1, the block sends one beat per cycle, so REPORT lasts `NUM_BANDS` cycles.

## Test plan
- **Single band hit:** `NUM_BANDS`=4, `MIN_HITS`=8. Send 8 edges at x=300 and 10 edges at x=1000, y=50. Required response:
  - band 0: left=300, right=1000, center=650, found=1/1.
  - bands 1–3: left=320, right=960, found=0/0.
- **Innermost selection:** left edges at x=100, 500, 200 and right edges at x=900, 700, 1100, each repeated ×8 in band 2. Required response: band 2 left=500, right=700.
- **Persistence:** frame 1 qualifies band 1 with left=400. Frame 2 has only 7 hits at x=600 in band 1. Required response: band 1 left=400, found_left=0.
- **Backpressure:** hold `result_ready`=0 for 5 cycles on band 1. Required response: band 1 outputs stay stable; all 4 beats are delivered in order; `frame_done` pulses once.
- **Skipped frame:** raise `vs_in` while in REPORT with `result_ready`=0. Required response: `skipped_frames`=1 and `processing` stays 0. Rising on the final-transfer cycle instead: ACCUM is entered and the counter is unchanged.
- **Reset and range:** assert `reset` mid-ACCUM. Required response: all outputs return to their reset values. Separately, x=1280 and y=720 samples leave all counters unchanged.
